bounce_sequencer: RTL
=====================

# bounce_sequencer

Controller that sequences an up/down counter through programmed "bounce" sweeps: from a low limit up to a high limit and back, repeated a programmed number of times. It latches its configuration on a start request, runs autonomously, and reports turn-around points and completion. It sits between the register/control logic and the counter datapath, replacing hand-driven `enable`/`up_down` sequencing.

## Interface
- `WIDTH`, 4: counter width in bits
- `CYC_W`, 4: width of the sweep-repeat count

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a run; sampled only in IDLE
- `abort`  in  1  terminate a run in progress; no `done` is generated
- `pause`  in  1  freeze count and state while high
- `lo_limit`  in  WIDTH  sweep low endpoint; latched on accepted start
- `hi_limit`  in  WIDTH  sweep high endpoint; latched on accepted start
- `cycles`  in  CYC_W  number of up+down sweeps; latched on accepted start
- `count`  out  WIDTH  current counter value
- `dir`  out  1  1 = counting up, 0 = counting down
- `busy`  out  1  high in UP and DOWN
- `turn`  out  1  one-cycle pulse in the cycle `count` first equals an endpoint during a run
- `done`  out  1  one-cycle pulse at normal completion
- `cycles_left`  out  CYC_W  sweeps remaining, including the current one

## Operation
- States: IDLE, UP, DOWN.
- Reset values: state IDLE, `count`=0, `dir`=1, `busy`=0, `turn`=0, `done`=0, `cycles_left`=0.
- IDLE with `start`=1:
  - If `lo_limit` >= `hi_limit` (unsigned) or `cycles`=0: the run is degenerate. Pulse `done` next cycle, leave `count` unchanged, stay in IDLE.
  - Otherwise, on the same edge: latch the limits, set `count`=`lo_limit`, `cycles_left`=`cycles`, `dir`=1, and go to UP.
- UP, not paused:
  - `count`+1 each edge.
  - On the edge where `count`+1 == hi: go to DOWN, set `dir`=0, `turn`=1.
- DOWN, not paused:
  - `count`-1 each edge.
  - On the edge where `count`-1 == lo: decrement `cycles_left`, set `turn`=1.
  - If the new `cycles_left`=0: go to IDLE, `done`=1, `dir`=1. Otherwise go to UP, `dir`=1.
- Priority: `reset` > `abort` > `pause` > normal stepping.
- `abort` in UP/DOWN: IDLE next edge; `count` holds its value; `cycles_left` is cleared; `dir`=1; no `turn` or `done`.
- `pause` in UP/DOWN: all registers hold; `turn`/`done` are 0.
- `start` outside IDLE is ignored. `pause`/`abort` in IDLE have no effect.
- Arithmetic is unsigned, WIDTH bits. Wrap-around cannot occur because lo < hi is enforced.
- Inputs `lo_limit`, `hi_limit` and `cycles` may change mid-run without effect; only the latched copies are used.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` accepted at edge T0 → `count`=lo and `busy`=1 visible after T0.
- One step per unpaused edge.
- A non-degenerate run completes `2*(hi-lo)*cycles` unpaused edges after T0.
- `done` and `busy`=0 appear together after the final edge. A new `start` is accepted the cycle after `done`.
- Degenerate start: `done` one edge after T0; `busy` never rises.
- `reset` asserted mid-run: all outputs reach reset values after that edge, regardless of other inputs.

## Structure
- Shared package `bounce_pkg`: state enum (IDLE/UP/DOWN) and default width constants `BOUNCE_WIDTH`=4, `BOUNCE_CYC_W`=4.
- One natural sub-module: `updown_step`, the WIDTH-bit loadable up/down counter.
  - Ports: `clk`, `reset`, `load`, `load_val`, `en`, `up`, `q`.
  - The FSM in `bounce_sequencer` drives `load`/`en`/`up` and performs endpoint compares on `q`±1.

## Test plan
- Reset, then lo=2, hi=5, cycles=1, start → `count` 2,3,4,5,4,3,2 on successive edges; `turn` with 5 and final 2; `done` with final 2; `busy` high for 6 cycles.
- lo=0, hi=15 (WIDTH=4), cycles=2 → reaches 15 twice with no wrap past 15 or below 0; `cycles_left` 2→1→0; `done` after 60 edges.
- lo=7, hi=7, start → `done` one edge later, `busy` stays 0, `count` unchanged. Repeat with cycles=0 and the same result is required.
- lo=1, hi=4, cycles=1; `pause` high for 3 cycles at count=3 → `count` holds at 3 for 3 cycles; `done` delayed by exactly 3 cycles.
- Mid-run at count=4: `abort` → IDLE, `count` stays 4, no `done`. Then reassert `start` while `busy` in a new run → ignored. Then `reset` at count=3 → all outputs return to reset values next edge.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared types and default sizes for the bounce sequencer.
package bounce_pkg;

   localparam int unsigned BOUNCE_WIDTH = 4;
   localparam int unsigned BOUNCE_CYC_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } bounce_state_e;

endpackage : bounce_pkg

// File: rtl/bounce_sequencer_updown_step.sv
// Loadable WIDTH-bit up/down counter stepped by the bounce sequencer.
module updown_step
   import bounce_pkg::*;
#(
   parameter int unsigned WIDTH = BOUNCE_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Load has priority over stepping; hold when neither is requested.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : updown_step

// File: rtl/bounce_sequencer.sv
// Sequences an up/down counter through repeated lo->hi->lo sweeps.
module bounce_sequencer
   import bounce_pkg::*;
#(
   parameter int unsigned WIDTH = BOUNCE_WIDTH,
   parameter int unsigned CYC_W = BOUNCE_CYC_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             pause,
   input  logic [WIDTH-1:0] lo_limit,
   input  logic [WIDTH-1:0] hi_limit,
   input  logic [CYC_W-1:0] cycles,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             busy,
   output logic             turn,
   output logic             done,
   output logic [CYC_W-1:0] cycles_left
);

   bounce_state_e    state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             turn_q, turn_d;
   logic             done_q, done_d;

   logic             ctr_load, ctr_en, ctr_up;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_inc, q_dec;
   logic             start_bad, at_hi, at_lo, last_sweep;

   assign q_inc      = q + WIDTH'(1);
   assign q_dec      = q - WIDTH'(1);
   assign start_bad  = (lo_limit >= hi_limit) || (cycles == '0);
   assign at_hi      = (q_inc == hi_q);
   assign at_lo      = (q_dec == lo_q);
   assign last_sweep = (cyc_q == CYC_W'(1));

   updown_step #(.WIDTH(WIDTH)) u_step (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (lo_limit),
      .en       (ctr_en),
      .up       (ctr_up),
      .q        (q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort beats pause beats stepping.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !start_bad) state_d = ST_UP;
         end
         ST_UP: begin
            if (abort)           state_d = ST_IDLE;
            else if (!pause && at_hi) state_d = ST_DOWN;
         end
         ST_DOWN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!pause && at_lo) begin
               state_d = last_sweep ? ST_IDLE : ST_UP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter controls and next values of the registered outputs.
   always_comb begin
      ctr_load = 1'b0;
      ctr_en   = 1'b0;
      ctr_up   = 1'b1;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cyc_d    = cyc_q;
      dir_d    = dir_q;
      turn_d   = 1'b0;
      done_d   = 1'b0;
      busy_d   = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (start_bad) begin
                  done_d = 1'b1;
               end else begin
                  ctr_load = 1'b1;
                  lo_d     = lo_limit;
                  hi_d     = hi_limit;
                  cyc_d    = cycles;
                  dir_d    = 1'b1;
               end
            end
         end
         ST_UP: begin
            if (abort) begin
               cyc_d = '0;
               dir_d = 1'b1;
            end else if (!pause) begin
               ctr_en = 1'b1;
               if (at_hi) begin
                  dir_d  = 1'b0;
                  turn_d = 1'b1;
               end
            end
         end
         ST_DOWN: begin
            if (abort) begin
               cyc_d = '0;
               dir_d = 1'b1;
            end else if (!pause) begin
               ctr_en = 1'b1;
               ctr_up = 1'b0;
               if (at_lo) begin
                  cyc_d  = cyc_q - CYC_W'(1);
                  turn_d = 1'b1;
                  dir_d  = 1'b1;
                  done_d = last_sweep;
               end
            end
         end
         default: ;
      endcase
   end

   // Latched configuration and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q   <= '0;
         hi_q   <= '0;
         cyc_q  <= '0;
         dir_q  <= 1'b1;
         busy_q <= 1'b0;
         turn_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         cyc_q  <= cyc_d;
         dir_q  <= dir_d;
         busy_q <= busy_d;
         turn_q <= turn_d;
         done_q <= done_d;
      end
   end

   assign count       = q;
   assign dir         = dir_q;
   assign busy        = busy_q;
   assign turn        = turn_q;
   assign done        = done_q;
   assign cycles_left = cyc_q;

endmodule : bounce_sequencer
